decode_scoreboard: RTL and testbench
====================================

# decode_scoreboard

Register-hazard scoreboard that sequences the decode stage of the pipelined core. For every register it tracks how many issued instructions still have an outstanding write. It stalls decode whenever a source operand, or an over-subscribed destination, would read or overwrite a stale register-file value. Sits beside the decode unit: it takes the rs1/rs2/rd fields being decoded and the register-file write port (write, write_reg), and drives the decode/fetch stall.

## Interface
- CORE, 0, core index printed in report output
- MAX_INFLIGHT, 3, maximum total outstanding writes, range 1..(2^CNT_W)-1
- CNT_W, 2, width of each per-register pending counter and of inflight_count
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- issue_valid  input  1  decode presents an instruction this cycle
- issue_rs1  input  5  source register 1 (instruction[19:15])
- issue_rs2  input  5  source register 2 (instruction[24:20])
- issue_use_rs1  input  1  instruction reads rs1
- issue_use_rs2  input  1  instruction reads rs2
- issue_rd  input  5  destination register (instruction[11:7])
- issue_writes  input  1  instruction writes rd
- wb_valid  input  1  register file write this cycle (same as regFile wEn)
- wb_reg  input  5  register being written (same as regFile write_sel)
- flush  input  1  pipeline flush; discard all pending entries
- report  input  1  print state via $display on this clock edge
- stall  output  1  decode must hold; instruction not accepted
- issue_accept  output  1  issue_valid && !stall
- pending_mask  output  32  bit i = register i has a nonzero counter
- inflight_count  output  CNT_W  total outstanding writes
- underflow_err  output  1  sticky: writeback to a register with a zero counter

## Operation
- Writes to x0 are never tracked: issue_writes with rd=0 does not count, and wb_reg=0 is ignored. Reads of x0 never stall.
- stall = issue_valid && any of:
  - (issue_use_rs1 && rs1≠0 && cnt[rs1]≠0)
  - (issue_use_rs2 && rs2≠0 && cnt[rs2]≠0)
  - (issue_writes && rd≠0 && (cnt[rd] saturated at 2^CNT_W-1 || inflight_count==MAX_INFLIGHT))
- stall is 0 when issue_valid is 0.
- On issue_accept with issue_writes && rd≠0: cnt[rd]+1 and inflight_count+1.
- On wb_valid with wb_reg≠0 and cnt[wb_reg]≠0: cnt[wb_reg]-1 and inflight_count-1.
- On wb_valid with wb_reg≠0 and cnt[wb_reg]==0: counters unchanged, underflow_err set to 1. It is cleared only by reset.
- Issue and writeback to the same register in the same cycle: net counter change is 0 (+1 and -1 both apply). Issue and writeback to different registers apply independently, and inflight_count nets correctly.
- flush has priority over everything: all counters and inflight_count go to 0 next cycle, and any simultaneous issue or writeback is discarded. underflow_err is unaffected.
- Counters never wrap. Saturation is prevented by stall, and underflow is prevented by the check above.
- report prints CORE, the cycle number, pending_mask, inflight_count, stall and the issue fields, in the same banner style used by the other pipeline units.

## Timing
- Reset (asynchronous, immediate): all counters 0, inflight_count 0, pending_mask 0, underflow_err 0.
  - stall and issue_accept follow issue_valid combinationally: stall 0; issue_accept 0 when issue_valid is 0.
- stall and issue_accept are combinational from the inputs and the registered counters only. There is no writeback bypass.
- A writeback in cycle N clears a hazard from cycle N+1. An instruction stalled in cycle N on that register is accepted in N+1.
- An issue in cycle N makes its rd pending from cycle N+1. A dependent instruction presented in N+1 stalls.
- pending_mask and inflight_count are registered and reflect updates one cycle after the event.
- Reset asserted mid-operation drops all pending state immediately, and no stall persists afterwards.

## Structure
- Shared definitions header: REG_COUNT=32, REG_ADDR_W=5, X0 index constant. The decode and writeback units use the same constants.
- One natural sub-module: sb_reg_counter, a per-register up/down counter with CNT_W width, a zero flag and a saturation flag, instantiated REG_COUNT-1 times (x1..x31) by generate.
- Top level holds the stall logic, the inflight counter, the sticky error, the cycle counter and report.

## Test plan
- Reset, then issue rd=5 writes, then rs1=5 in the next cycle → first accepted, second stall=1; wb_reg=5 → pending_mask[5]=0 next cycle and the dependent instruction is accepted.
- Issue rd=0 writes, then rs1=0 → no stall, inflight_count stays 0, pending_mask=0.
- Issue writes to rd=1,2,3 (MAX_INFLIGHT=3), then a fourth to rd=4 → stall=1 until any writeback, then accepted; inflight_count returns to 3.
- Same-cycle issue rd=7 and wb_reg=7 with cnt[7]=1 → cnt[7] stays 1, inflight_count unchanged, pending_mask[7]=1.
- wb_valid with wb_reg=9 and cnt[9]=0 → underflow_err=1 and it stays 1 through flush; only reset clears it.
- Pending writes to rd=1,2 plus flush asserted together with an issue rd=3 → next cycle all counters 0, pending_mask=0, inflight_count=0.
- Reset asserted mid-stall → pending_mask=0 and stall=0 immediately.

Source files
------------

// File: rtl/decode_scoreboard_pkg.sv
// Register-file constants and issue-field types for the decode scoreboard.
// The decode and writeback units use the same definitions.
package decode_scoreboard_pkg;
   localparam int REG_COUNT  = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t X0 = '0;

   // x0 is hardwired zero, so it never carries a hazard.
   function automatic logic is_tracked(input reg_addr_t r);
      return r != X0;
   endfunction
endpackage

// File: rtl/decode_scoreboard_sb_reg_counter.sv
// Up/down counter of outstanding writes for one architectural register.
// Zero and saturation flags are consumed by the hazard logic in the top.
module sb_reg_counter #(
   parameter int CNT_W = 2
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_zero,
   output logic o_sat
);
   logic [CNT_W-1:0] r_cnt;

   assign o_zero = (r_cnt == '0);
   assign o_sat  = (r_cnt == '1);

   // An inc and dec landing together cancel out.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_inc && !i_dec && !o_sat)
         r_cnt <= r_cnt + CNT_W'(1);
      else if (i_dec && !i_inc && !o_zero)
         r_cnt <= r_cnt - CNT_W'(1);
   end
endmodule

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard for the decode stage: tracks outstanding writes
// per register and stalls decode on RAW hazards or write over-subscription.
module decode_scoreboard
   import decode_scoreboard_pkg::*;
#(
   parameter int CORE         = 0,
   parameter int MAX_INFLIGHT = 3,
   parameter int CNT_W        = 2
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_issue_valid,
   input  logic [4:0]       i_issue_rs1,
   input  logic [4:0]       i_issue_rs2,
   input  logic             i_issue_use_rs1,
   input  logic             i_issue_use_rs2,
   input  logic [4:0]       i_issue_rd,
   input  logic             i_issue_writes,
   input  logic             i_wb_valid,
   input  logic [4:0]       i_wb_reg,
   input  logic             i_flush,
   input  logic             i_report,
   output logic             o_stall,
   output logic             o_issue_accept,
   output logic [31:0]      o_pending_mask,
   output logic [CNT_W-1:0] o_inflight_count,
   output logic             o_underflow_err
);
   logic [REG_COUNT-1:0] w_zero, w_sat;
   logic                 w_rs1_hz, w_rs2_hz, w_rd_hz, w_full;
   logic                 w_inc, w_dec, w_uf;
   logic [CNT_W-1:0]     r_inflight;
   logic                 r_uf;
   logic [31:0]          r_cycle;

   assign w_zero[0] = 1'b1;
   assign w_sat[0]  = 1'b0;

   for (genvar i = 1; i < REG_COUNT; i++) begin : g_cnt
      sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
         .i_clock (i_clock),
         .i_reset (i_reset),
         .i_clear (i_flush),
         .i_inc   (w_inc && (i_issue_rd == reg_addr_t'(i))),
         .i_dec   (w_dec && (i_wb_reg == reg_addr_t'(i))),
         .o_zero  (w_zero[i]),
         .o_sat   (w_sat[i])
      );
   end

   // Hazards look only at registered counters; a same-cycle writeback is not bypassed.
   assign w_full   = (r_inflight == CNT_W'(MAX_INFLIGHT));
   assign w_rs1_hz = i_issue_use_rs1 && is_tracked(i_issue_rs1) && !w_zero[i_issue_rs1];
   assign w_rs2_hz = i_issue_use_rs2 && is_tracked(i_issue_rs2) && !w_zero[i_issue_rs2];
   assign w_rd_hz  = i_issue_writes && is_tracked(i_issue_rd) && (w_sat[i_issue_rd] || w_full);

   assign o_stall        = i_issue_valid && (w_rs1_hz || w_rs2_hz || w_rd_hz);
   assign o_issue_accept = i_issue_valid && !o_stall;

   assign w_inc = !i_flush && o_issue_accept && i_issue_writes && is_tracked(i_issue_rd);
   assign w_dec = !i_flush && i_wb_valid && is_tracked(i_wb_reg) && !w_zero[i_wb_reg];
   assign w_uf  = !i_flush && i_wb_valid && is_tracked(i_wb_reg) && w_zero[i_wb_reg];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_inflight <= '0;
         r_uf       <= 1'b0;
         r_cycle    <= '0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_uf)
            r_uf <= 1'b1;
         if (i_flush)
            r_inflight <= '0;
         else if (w_inc && !w_dec)
            r_inflight <= r_inflight + CNT_W'(1);
         else if (w_dec && !w_inc)
            r_inflight <= r_inflight - CNT_W'(1);
      end
   end

   assign o_pending_mask   = ~w_zero;
   assign o_inflight_count = r_inflight;
   assign o_underflow_err  = r_uf;

`ifndef SYNTHESIS
   always_ff @(posedge i_clock) begin
      if (i_report)
         $display("==== [decode_scoreboard core %0d] cycle %0d ==== pend=%08h inflight=%0d stall=%0b v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b",
                  CORE, r_cycle, o_pending_mask, r_inflight, o_stall, i_issue_valid,
                  i_issue_rs1, i_issue_use_rs1, i_issue_rs2, i_issue_use_rs2,
                  i_issue_rd, i_issue_writes);
   end
`endif
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard with hand-computed expectations.
module tb_decode_scoreboard;
   logic        clk = 1'b0, rst = 1'b1;
   logic        iv, u1, u2, wr, wbv, fl, rep;
   logic [4:0]  rs1, rs2, rd, wbr;
   logic        stall, acc, uf;
   logic [31:0] pend;
   logic [1:0]  infl;
   int          checks = 0, errors = 0;

   decode_scoreboard #(.CORE(0), .MAX_INFLIGHT(3), .CNT_W(2)) dut (
      .i_clock(clk), .i_reset(rst), .i_issue_valid(iv), .i_issue_rs1(rs1),
      .i_issue_rs2(rs2), .i_issue_use_rs1(u1), .i_issue_use_rs2(u2),
      .i_issue_rd(rd), .i_issue_writes(wr), .i_wb_valid(wbv), .i_wb_reg(wbr),
      .i_flush(fl), .i_report(rep), .o_stall(stall), .o_issue_accept(acc),
      .o_pending_mask(pend), .o_inflight_count(infl), .o_underflow_err(uf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      iv = 0; u1 = 0; u2 = 0; wr = 0; wbv = 0; fl = 0; rep = 0;
      rs1 = 0; rs2 = 0; rd = 0; wbr = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue_wr(input logic [4:0] r);
      iv = 1; wr = 1; rd = r;
   endtask

   task automatic wb(input logic [4:0] r);
      wbv = 1; wbr = r;
   endtask

   initial begin
      idle();
      #1;
      chk("rst_pend", pend, 0);
      chk("rst_infl", 32'(infl), 0);
      chk("rst_uf", 32'(uf), 0);
      chk("rst_stall_idle", 32'(stall), 0);
      chk("rst_acc_idle", 32'(acc), 0);
      #6 rst = 0;
      step(); idle();

      // RAW on x5, cleared by writeback
      issue_wr(5); #1;
      chk("t1_acc", 32'(acc), 1);
      step(); idle();
      chk("t1_pend", pend, 32'h20);
      chk("t1_infl", 32'(infl), 1);
      iv = 1; u1 = 1; rs1 = 5; #1;
      chk("t1_raw_stall", 32'(stall), 1);
      chk("t1_raw_acc", 32'(acc), 0);
      step();
      wb(5); #1;
      chk("t1_no_bypass", 32'(stall), 1);
      step(); wbv = 0; #1;
      chk("t1_wb_pend", pend, 0);
      chk("t1_dep_acc", 32'(acc), 1);
      step(); idle();

      // x0 never tracked
      issue_wr(0); u1 = 1; rs1 = 0; #1;
      chk("t2_acc", 32'(acc), 1);
      step(); idle();
      chk("t2_infl", 32'(infl), 0);
      chk("t2_pend", pend, 0);

      // MAX_INFLIGHT limit
      issue_wr(1); step(); issue_wr(2); step(); issue_wr(3); rep = 1; step(); rep = 0;
      chk("t3_infl3", 32'(infl), 3);
      chk("t3_pend", pend, 32'h0E);
      issue_wr(4); #1;
      chk("t3_full_stall", 32'(stall), 1);
      step();
      chk("t3_still_stall", 32'(stall), 1);
      wb(1); step(); wbv = 0; #1;
      chk("t3_infl2", 32'(infl), 2);
      chk("t3_acc", 32'(acc), 1);
      step(); idle();
      chk("t3_infl_back", 32'(infl), 3);
      chk("t3_pend2", pend, 32'h1C);

      // drain, then same-cycle issue and writeback on x7
      wb(2); step(); wb(3); step(); wb(4); step(); idle();
      chk("t4_drained", 32'(infl), 0);
      issue_wr(7); step(); idle();
      issue_wr(7); wb(7); #1;
      chk("t4_acc", 32'(acc), 1);
      step(); idle();
      chk("t4_pend", pend, 32'h80);
      chk("t4_infl", 32'(infl), 1);
      wb(7); step(); idle();
      chk("t4_clear", pend, 0);

      // underflow: x0 writeback ignored, x9 with zero counter flags
      wb(0); step(); idle();
      chk("t5_x0_uf", 32'(uf), 0);
      wb(9); step(); idle();
      chk("t5_uf", 32'(uf), 1);
      chk("t5_infl", 32'(infl), 0);

      // flush beats simultaneous issue and writeback
      issue_wr(1); step(); issue_wr(2); step(); idle();
      chk("t6_pre", pend, 32'h06);
      fl = 1; issue_wr(3); wb(1); step(); idle();
      chk("t6_pend", pend, 0);
      chk("t6_infl", 32'(infl), 0);
      chk("t6_uf_sticky", 32'(uf), 1);

      // async reset mid-stall
      issue_wr(5); step(); idle();
      iv = 1; u2 = 1; rs2 = 5; #1;
      chk("t7_stall", 32'(stall), 1);
      #2 rst = 1; #1;
      chk("t7_pend", pend, 0);
      chk("t7_stall_gone", 32'(stall), 0);
      chk("t7_uf", 32'(uf), 0);
      step(); rst = 0; idle(); step();
      chk("t7_infl", 32'(infl), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
